alu_sequencer: RTL

Instruction sequencer for the 16-bit accumulator ALU. It accepts opcode/operand pairs over a valid/ready handshake and decodes each opcode into the ALU's one-hot control strobes. It owns the accumulator register that feeds the ALU's AC input, and it waits on the external 8x8 multiplier for the multiply opcode. It sits between the instruction source and the ALU/multiplier pair.

---
 rtl/alu_sequencer_if.sv | 39 +++
 rtl/alu_sequencer.sv | 106 ++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Bundle between the instruction source, the accumulator ALU, the 8x8 multiplier
// and the ALU sequencer. The slave modport is the sequencer's view.
interface alu_sequencer_if #(
    parameter int unsigned CNT_W = 8
);
    logic             InstrValid;
    logic             InstrReady;
    logic [2:0]       Opcode;
    logic [15:0]      InstrData;
    logic [15:0]      DataInput;
    logic [15:0]      AC_Out;
    logic [15:0]      AluOut;
    logic             Reset_AC;
    logic             ShiftRight_AC;
    logic             Add_Input_AC;
    logic             Increment_AC;
    logic             Swaprightleft_AC;
    logic             Complement_AC;
    logic             Multiply_AC;
    logic             MulDone;
    logic [15:0]      Product;
    logic             Done;
    logic             Error;
    logic [CNT_W-1:0] InstrCount;

    modport master (
        output InstrValid, Opcode, InstrData, AluOut, MulDone, Product,
        input  InstrReady, DataInput, AC_Out, Reset_AC, ShiftRight_AC, Add_Input_AC,
               Increment_AC, Swaprightleft_AC, Complement_AC, Multiply_AC, Done, Error,
               InstrCount
    );

    modport slave (
        input  InstrValid, Opcode, InstrData, AluOut, MulDone, Product,
        output InstrReady, DataInput, AC_Out, Reset_AC, ShiftRight_AC, Add_Input_AC,
               Increment_AC, Swaprightleft_AC, Complement_AC, Multiply_AC, Done, Error,
               InstrCount
    );
endinterface

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 16-bit accumulator ALU: accepts opcode/operand pairs,
// drives one-hot ALU strobes, owns the accumulator and waits on the multiplier.
module alu_sequencer #(
    parameter int unsigned MUL_TIMEOUT = 32,
    parameter int unsigned CNT_W       = 8
) (
    input logic            Clock,
    input logic            ResetN,
    alu_sequencer_if.slave bus
);

    localparam logic [2:0] OpMul       = 3'b110;
    localparam logic [2:0] OpIllegal   = 3'b111;
    localparam logic [7:0] TimeoutLast = 8'(MUL_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StExec, StMulWait} state_e;

    state_e           state_q;
    logic [2:0]       op_q;
    logic [15:0]      data_q;
    logic [15:0]      ac_q;
    logic [6:0]       strobe_q;
    logic             ready_q;
    logic             done_q;
    logic             error_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       tmo_q;

    // Strobe bit i corresponds to opcode i; the illegal opcode selects no ALU function.
    function automatic logic [6:0] decode(input logic [2:0] op);
        if (op == OpIllegal) begin
            return 7'b0000000;
        end
        return 7'b0000001 << op;
    endfunction

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q  <= StIdle;
            op_q     <= 3'b000;
            data_q   <= 16'h0000;
            ac_q     <= 16'h0000;
            strobe_q <= 7'b0000000;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            count_q  <= '0;
            tmo_q    <= 8'd0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.InstrValid && ready_q) begin
                        op_q     <= bus.Opcode;
                        data_q   <= bus.InstrData;
                        strobe_q <= decode(bus.Opcode);
                        ready_q  <= 1'b0;
                        state_q  <= StExec;
                    end
                end
                StExec: begin
                    if (op_q == OpMul) begin
                        tmo_q   <= 8'd0;
                        state_q <= StMulWait;
                    end else begin
                        ac_q     <= (op_q == OpIllegal) ? 16'h0000 : bus.AluOut;
                        strobe_q <= 7'b0000000;
                        done_q   <= 1'b1;
                        count_q  <= count_q + CNT_W'(1);
                        ready_q  <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                StMulWait: begin
                    tmo_q <= tmo_q + 8'd1;
                    // A result arriving on the timeout cycle still counts as success.
                    if (bus.MulDone || (tmo_q == TimeoutLast)) begin
                        if (bus.MulDone) begin
                            ac_q <= bus.Product;
                        end else begin
                            error_q <= 1'b1;
                        end
                        strobe_q <= 7'b0000000;
                        done_q   <= 1'b1;
                        count_q  <= count_q + CNT_W'(1);
                        ready_q  <= 1'b1;
                        state_q  <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.InstrReady = ready_q;
    assign bus.DataInput  = data_q;
    assign bus.AC_Out     = ac_q;
    assign bus.Done       = done_q;
    assign bus.Error      = error_q;
    assign bus.InstrCount = count_q;
    assign {bus.Multiply_AC, bus.Complement_AC, bus.Swaprightleft_AC, bus.Increment_AC,
            bus.Add_Input_AC, bus.ShiftRight_AC, bus.Reset_AC} = strobe_q;

endmodule
